majority_self_test: RTL and testbench

//   Synthesizable on-board checker for the 3-input majority voter.

---
 rtl/majority_self_test_if.sv | 27 ++
 rtl/majority_self_test.sv | 131 +++++++++++++
 tb/tb_majority_self_test.sv | 196 +++++++++++++++++++
 3 files changed

// File: rtl/majority_self_test_if.sv
// Voter-checker bus: stimulus out to the voter, its answer back, and the result flags.
// Combinational only; there is no backpressure.
// master = checker side, slave = voter / board side.
interface majority_self_test_if #(
    parameter int ERR_W = 4
);
    logic             start;
    logic             x;
    logic             y;
    logic             z;
    logic             p;
    logic             busy;
    logic             done;
    logic             pass;
    logic [ERR_W-1:0] err_cnt;
    logic [7:0]       fail_vec;

    modport master (
        input  start, p,
        output x, y, z, busy, done, pass, err_cnt, fail_vec
    );

    modport slave (
        output start, p,
        input  x, y, z, busy, done, pass, err_cnt, fail_vec
    );
endinterface

// File: rtl/majority_self_test.sv
// On-board checker: sweeps all 8 {x,y,z} vectors into a majority voter and scores its answers.
// Latency: done rises 1+8*(SETTLE_CYCLES+1) cycles after start (+2 per vector with MAJ_CHK_SYNC_EN).
// Backpressure: none; start is level-sampled and only honoured in IDLE or DONE.
module majority_self_test #(
    parameter int SETTLE_CYCLES = 4,
    parameter int ERR_W         = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    majority_self_test_if.master bus
);
    typedef enum logic [1:0] {IDLE, SETTLE, SAMPLE, DONE} state_t;

`ifdef MAJ_CHK_SYNC_EN
    localparam int LOAD = SETTLE_CYCLES + 2;
`else
    localparam int LOAD = SETTLE_CYCLES;
`endif
    localparam int CNT_W = $clog2(LOAD + 1);

    state_t           state_q, state_d;
    logic [2:0]       idx_q, idx_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             pass_q, pass_d;
    logic [ERR_W-1:0] err_q, err_d;
    logic [7:0]       fail_q, fail_d;

    logic             p_s;
    logic             exp_p;
    logic             mism;
    logic [ERR_W-1:0] err_nxt;

`ifdef MAJ_CHK_SYNC_EN
    logic p_meta_q, p_sync_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            p_meta_q <= 1'b0;
            p_sync_q <= 1'b0;
        end else begin
            p_meta_q <= bus.p;
            p_sync_q <= p_meta_q;
        end
    end
    assign p_s = p_sync_q;
`else
    assign p_s = bus.p;
`endif

    assign exp_p   = (idx_q[2] & idx_q[1]) | (idx_q[1] & idx_q[0]) | (idx_q[2] & idx_q[0]);
    assign mism    = p_s ^ exp_p;
    assign err_nxt = (mism && (err_q != {ERR_W{1'b1}})) ? err_q + ERR_W'(1) : err_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            idx_q   <= 3'd0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
            err_q   <= '0;
            fail_q  <= 8'h00;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            pass_q  <= pass_d;
            err_q   <= err_d;
            fail_q  <= fail_d;
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        busy_d  = busy_q;
        done_d  = done_q;
        pass_d  = pass_q;
        err_d   = err_q;
        fail_d  = fail_q;
        case (state_q)
            IDLE, DONE: begin
                if (bus.start) begin
                    state_d = SETTLE;
                    idx_d   = 3'd0;
                    cnt_d   = CNT_W'(LOAD);
                    busy_d  = 1'b1;
                    done_d  = 1'b0;
                    pass_d  = 1'b0;
                    err_d   = '0;
                    fail_d  = 8'h00;
                end
            end
            SETTLE: begin
                if (cnt_q == CNT_W'(1)) state_d = SAMPLE;
                else                    cnt_d   = cnt_q - CNT_W'(1);
            end
            SAMPLE: begin
                err_d = err_nxt;
                if (mism) fail_d[idx_q] = 1'b1;
                // idx wraps 7->0 here, so x,y,z return to 0 on entering DONE
                idx_d = idx_q + 3'd1;
                if (idx_q == 3'd7) begin
                    state_d = DONE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    pass_d  = (err_nxt == '0);
                end else begin
                    state_d = SETTLE;
                    cnt_d   = CNT_W'(LOAD);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.x        = idx_q[2];
    assign bus.y        = idx_q[1];
    assign bus.z        = idx_q[0];
    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.pass     = pass_q;
    assign bus.err_cnt  = err_q;
    assign bus.fail_vec = fail_q;
endmodule

// File: tb/tb_majority_self_test.sv
// Bench for majority_self_test: scoreboarded sweeps against good and faulty voters,
// plus a saturating ERR_W=2 instance, mid-sweep reset, re-pulsed and held start.
module tb_majority_self_test;
    localparam int SC = 4;
`ifdef MAJ_CHK_SYNC_EN
    localparam int V = SC + 3;
`else
    localparam int V = SC + 1;
`endif

    typedef struct {
        int         lat;
        logic [3:0] err;
        logic [7:0] fail;
        logic       pass;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   mode = 0;
    int   n_chk = 0;
    int   n_bad = 0;
    exp_t sb[$];

    always #5 clk = ~clk;

    majority_self_test_if #(.ERR_W(4)) bus  ();
    majority_self_test_if #(.ERR_W(2)) bus2 ();

    always_comb begin
        case (mode)
            0:       bus.p = (bus.x & bus.y) | (bus.y & bus.z) | (bus.x & bus.z);
            1:       bus.p = 1'b0;
            2:       bus.p = bus.x;
            default: bus.p = 1'b1;
        endcase
    end
    assign bus2.start = bus.start;
    assign bus2.p     = 1'b1;

    majority_self_test #(.SETTLE_CYCLES(SC), .ERR_W(4)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus.master)
    );
    majority_self_test #(.SETTLE_CYCLES(SC), .ERR_W(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .bus(bus2.master)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    function automatic exp_t model(input int m);
        exp_t e;
        logic [2:0] v;
        logic maj, pv;
        e.lat  = 1 + 8 * V;
        e.err  = 4'd0;
        e.fail = 8'h00;
        for (int i = 0; i < 8; i++) begin
            v   = 3'(i);
            maj = (v[2] & v[1]) | (v[1] & v[0]) | (v[2] & v[0]);
            case (m)
                0:       pv = maj;
                1:       pv = 1'b0;
                2:       pv = v[2];
                default: pv = 1'b1;
            endcase
            if (pv != maj) begin
                e.fail[i] = 1'b1;
                if (e.err != 4'hF) e.err = e.err + 4'd1;
            end
        end
        e.pass = (e.err == 4'd0);
        return e;
    endfunction

    task automatic sweep(input int m, input bit repulse);
        exp_t e;
        int   n;
        bit   seen;
        mode = m;
        sb.push_back(model(m));
        @(negedge clk);
        bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        n = 1;
        chk("busy_rise", bus.busy, 1);
        chk("done_clr", bus.done, 0);
        chk("err_clr", bus.err_cnt, 0);
        chk("xyz_first", {bus.x, bus.y, bus.z}, 0);
        seen = 0;
        while (!seen && n < 400) begin
            bus.start = (repulse && n == 12);
            @(posedge clk); #1;
            n++;
            if (bus.done) seen = 1;
        end
        bus.start = 1'b0;
        e = sb.pop_front();
        chk("done_lat", n, e.lat);
        chk("err_cnt", bus.err_cnt, e.err);
        chk("fail_vec", bus.fail_vec, e.fail);
        chk("pass", bus.pass, e.pass);
        chk("busy_end", bus.busy, 0);
        chk("xyz_end", {bus.x, bus.y, bus.z}, 0);
        chk("sat_err", bus2.err_cnt, 3);
        chk("sat_fail", bus2.fail_vec, 8'h17);
        chk("sat_pass", bus2.pass, 0);
        repeat (3) @(posedge clk);
        #1;
        chk("done_hold", bus.done, 1);
        chk("fail_hold", bus.fail_vec, e.fail);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        bus.start = 1'b0;
        #22;
        chk("rst_busy", bus.busy, 0);
        chk("rst_done", bus.done, 0);
        chk("rst_pass", bus.pass, 0);
        chk("rst_err", bus.err_cnt, 0);
        chk("rst_fail", bus.fail_vec, 0);
        chk("rst_xyz", {bus.x, bus.y, bus.z}, 0);
        @(negedge clk);
        rst_n = 1'b1;

        sweep(0, 0);
        sweep(1, 0);
        sweep(1, 0);
        sweep(2, 0);
        sweep(3, 0);
        sweep(0, 1);

        // abort during vector 3 with a voter that has already failed 0..2
        mode = 3;
        @(negedge clk);
        bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        n = 0;
        while ({bus.x, bus.y, bus.z} != 3'd3 && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        chk("reach_v3", {bus.x, bus.y, bus.z}, 3);
        chk("pre_rst_err", bus.err_cnt, 3);
        chk("pre_rst_fail", bus.fail_vec, 8'h07);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_busy", bus.busy, 0);
        chk("arst_xyz", {bus.x, bus.y, bus.z}, 0);
        chk("arst_err", bus.err_cnt, 0);
        chk("arst_fail", bus.fail_vec, 0);
        @(negedge clk);
        rst_n = 1'b1;
        sweep(0, 0);

        // start held high: one DONE cycle, then straight into a new sweep
        mode = 0;
        @(negedge clk);
        bus.start = 1'b1;
        n = 0;
        do begin
            @(posedge clk); #1;
            n++;
        end while (!bus.done && n < 400);
        chk("held_done", bus.done, 1);
        @(posedge clk); #1;
        chk("held_restart_busy", bus.busy, 1);
        chk("held_restart_done", bus.done, 0);
        bus.start = 1'b0;
        n = 0;
        while (!bus.done && n < 400) begin
            @(posedge clk); #1;
            n++;
        end
        chk("held_lat", n, 8 * V);
        chk("held_pass", bus.pass, 1);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end
endmodule
